// File: rtl/lock_clear_if.sv
// Signals between lock_clear_ctrl, the falling-piece logic and the board row RAM.
// lock_req is a level sampled only while busy is low and top_out is clear; there is no
// separate ready: busy low is the acceptance window. The RAM port has no handshake.
interface lock_clear_if #(
  parameter int COLS = 10
);
  logic            lock_req;
  logic [19:0]     x_block;
  logic [19:0]     y_block;
  logic            busy;
  logic [4:0]      row_addr;
  logic            row_we;
  logic [COLS-1:0] row_wdata;
  logic [COLS-1:0] row_rdata;
  logic            spawn_req;
  logic            clear_done;
  logic [2:0]      lines_cleared;
  logic [15:0]     total_lines;
  logic            top_out;

  modport master (
    input  lock_req, x_block, y_block, row_rdata,
    output busy, row_addr, row_we, row_wdata, spawn_req, clear_done,
           lines_cleared, total_lines, top_out
  );

  modport slave (
    output lock_req, x_block, y_block, row_rdata,
    input  busy, row_addr, row_we, row_wdata, spawn_req, clear_done,
           lines_cleared, total_lines, top_out
  );
endinterface

// File: rtl/lock_clear_ctrl.sv
// Lock/line-clear sequencer: writes a locked piece into the board RAM, compacts full
// rows downward, refills the top, and tracks line totals and top-out.
module lock_clear_ctrl #(
  parameter int COLS         = 10,
  parameter int ROWS         = 20,
  parameter int LOCK_OUT_ROW = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  lock_clear_if.master       bus,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    LK_RD   = 3'd2,
    LK_WR   = 3'd3,
    SC_RD   = 3'd4,
    SC_EVAL = 3'd5,
    FILL    = 3'd6,
    DONE    = 3'd7
  } state_t;

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  state_t          state;
  logic [4:0]      init_cnt;
  logic [3:0][4:0] xq;
  logic [3:0][4:0] yq;
  logic [1:0]      k;
  logic [4:0]      src;
  logic [4:0]      dst;
  logic [4:0]      cnt;
  logic            spawn_q;
  logic [2:0]      lines_q;
  logic [15:0]     total_q;
  logic            top_q;

  logic [4:0]      x_cur;
  logic [4:0]      y_cur;
  logic            cell_ok;
  logic            row_full;
  logic [COLS-1:0] cell_mask;
  logic            lock_topout;
  logic [4:0]      cnt_nxt;
  logic            done_entry;
  logic [16:0]     total_sum;

  assign x_cur    = xq[k];
  assign y_cur    = yq[k];
  assign cell_ok  = (x_cur < 5'(COLS)) && (y_cur < 5'(ROWS));
  assign row_full = &bus.row_rdata;

  always_comb begin
    cell_mask = '0;
    for (int i = 0; i < COLS; i++) begin
      cell_mask[i] = (x_cur == 5'(i));
    end
  end

  always_comb begin
    lock_topout = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.y_block[i*5 +: 5] < 5'(LOCK_OUT_ROW)) lock_topout = 1'b1;
    end
  end

  // cnt_nxt folds in the row being judged this cycle so the FILL/DONE decision sees it.
  assign cnt_nxt    = cnt + {4'd0, (state == SC_EVAL) && row_full};
  assign done_entry = ((state == SC_EVAL) && (src == 5'd0) && (cnt_nxt == 5'd0)) ||
                      ((state == FILL) && (dst == 5'd0));
  assign total_sum  = {1'b0, total_q} + {12'd0, cnt_nxt};

  // The RAM port depends on row_rdata in the same cycle, so it is decoded, not registered.
  always_comb begin
    bus.row_we    = 1'b0;
    bus.row_addr  = '0;
    bus.row_wdata = '0;
    case (state)
      INIT: begin
        if (init_cnt != 5'd0) begin
          bus.row_we   = 1'b1;
          bus.row_addr = init_cnt - 5'd1;
        end
      end
      LK_RD: bus.row_addr = y_cur;
      LK_WR: begin
        bus.row_addr  = y_cur;
        bus.row_we    = cell_ok;
        bus.row_wdata = bus.row_rdata | cell_mask;
      end
      SC_RD: bus.row_addr = src;
      SC_EVAL: begin
        if (row_full) begin
          bus.row_addr = src;
        end else begin
          bus.row_we    = 1'b1;
          bus.row_addr  = dst;
          bus.row_wdata = bus.row_rdata;
        end
      end
      FILL: begin
        bus.row_we   = 1'b1;
        bus.row_addr = dst;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= INIT;
      init_cnt <= '0;
      xq       <= '0;
      yq       <= '0;
      k        <= '0;
      src      <= '0;
      dst      <= '0;
      cnt      <= '0;
      spawn_q  <= 1'b0;
      lines_q  <= '0;
      total_q  <= '0;
      top_q    <= 1'b0;
    end else begin
      spawn_q <= 1'b0;
      if (done_entry) begin
        lines_q <= (cnt_nxt > 5'd7) ? 3'd7 : cnt_nxt[2:0];
        total_q <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
        spawn_q <= ~top_q;
      end
      case (state)
        INIT: begin
          if (init_cnt == 5'(ROWS)) begin
            state   <= IDLE;
            spawn_q <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 5'd1;
          end
        end
        IDLE: begin
          if (bus.lock_req && !top_q) begin
            xq    <= bus.x_block;
            yq    <= bus.y_block;
            k     <= '0;
            state <= LK_RD;
            if (lock_topout) top_q <= 1'b1;
          end
        end
        LK_RD: state <= LK_WR;
        LK_WR: begin
          if (k == 2'd3) begin
            src   <= LAST_ROW;
            dst   <= LAST_ROW;
            cnt   <= '0;
            state <= SC_RD;
          end else begin
            k     <= k + 2'd1;
            state <= LK_RD;
          end
        end
        SC_RD: state <= SC_EVAL;
        SC_EVAL: begin
          cnt <= cnt_nxt;
          if (!row_full && (dst != 5'd0)) dst <= dst - 5'd1;
          if (src == 5'd0) begin
            state <= (cnt_nxt != 5'd0) ? FILL : DONE;
          end else begin
            src   <= src - 5'd1;
            state <= SC_RD;
          end
        end
        FILL: begin
          if (dst == 5'd0) state <= DONE;
          else             dst   <= dst - 5'd1;
        end
        DONE: state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end

  assign bus.busy          = (state != IDLE);
  assign bus.clear_done    = (state == DONE);
  assign bus.spawn_req     = spawn_q;
  assign bus.lines_cleared = lines_q;
  assign bus.total_lines   = total_q;
  assign bus.top_out       = top_q;
  assign state_dbg         = state;

endmodule

// File: tb/tb_lock_clear_ctrl.sv
// Directed bench for lock_clear_ctrl with a behavioural board RAM (registered read).
module tb_lock_clear_ctrl;
  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam logic [2:0] S_INIT = 3'd0, S_IDLE = 3'd1, S_LK_RD = 3'd2, S_LK_WR = 3'd3;
  localparam logic [2:0] S_SC_RD = 3'd4, S_SC_EVAL = 3'd5, S_FILL = 3'd6;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  lock_clear_if #(.COLS(COLS)) bus ();
  logic [2:0] state_dbg;

  lock_clear_ctrl #(.COLS(COLS), .ROWS(ROWS), .LOCK_OUT_ROW(2)) dut (
    .Clk       (clk),
    .Reset     (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // board RAM model; preload port is used only while the DUT is not writing
  logic [COLS-1:0] mem [0:31];
  logic [COLS-1:0] rdata_q = '0;
  int              wr_cnt = 0;
  logic            pl_en = 1'b0;
  logic [4:0]      pl_addr = '0;
  logic [COLS-1:0] pl_data = '0;

  always @(posedge clk) begin
    rdata_q <= mem[bus.row_addr];
    if (bus.row_we) begin
      mem[bus.row_addr] <= bus.row_wdata;
      wr_cnt <= wr_cnt + 1;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end
  end
  assign bus.row_rdata = rdata_q;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic preload(input logic [4:0] a, input logic [COLS-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic reset_and_init();
    int bad;
    logic [COLS-1:0] z;
    rst = 1'b1;
    bus.lock_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", state_dbg, S_INIT);
    check("rst_we", bus.row_we, 0);
    check("rst_addr", bus.row_addr, 0);
    check("rst_busy", bus.busy, 1);
    check("rst_spawn", bus.spawn_req, 0);
    check("rst_done", bus.clear_done, 0);
    check("rst_lines", bus.lines_cleared, 0);
    check("rst_total", bus.total_lines, 0);
    check("rst_topout", bus.top_out, 0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < ROWS; i++) begin
      @(negedge clk);
      if (!(bus.row_we && bus.row_addr == 5'(i) && bus.row_wdata == '0 &&
            bus.busy && !bus.spawn_req)) bad++;
    end
    check("init_writes", bad, 0);
    @(negedge clk);
    check("init_spawn", bus.spawn_req, 1);
    check("init_idle_busy", bus.busy, 0);
    check("init_exit_we", bus.row_we, 0);
    @(negedge clk);
    check("init_spawn_pulse", bus.spawn_req, 0);
    z = '0;
    for (int r = 0; r < ROWS; r++) z = z | mem[r];
    check("board_clear", z, 0);
  endtask

  task automatic do_lock(input logic [19:0] x, input logic [19:0] y, input bit hold,
                         output int lat, output int fills, output int lk_after_sc);
    bit seen_sc;
    @(negedge clk);
    bus.x_block = x; bus.y_block = y; bus.lock_req = 1'b1;
    lat = 0; fills = 0; lk_after_sc = 0; seen_sc = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (!hold) bus.lock_req = 1'b0;
      if (state_dbg == S_FILL) fills++;
      if (state_dbg == S_SC_RD) seen_sc = 1;
      if (seen_sc && (state_dbg == S_LK_RD || state_dbg == S_LK_WR)) lk_after_sc++;
      if (bus.clear_done) break;
    end
    bus.lock_req = 1'b0;
  endtask

  int lat, fills, lk_sc, w0, busy_cnt, t;
  logic [COLS-1:0] z;

  initial begin
    bus.lock_req = 1'b0; bus.x_block = '0; bus.y_block = '0;
    for (int r = 0; r < ROWS; r++) preload(5'(r), COLS'($urandom_range(1, 1023)));
    reset_and_init();

    // single row write, no clear
    w0 = wr_cnt;
    do_lock({5'd6, 5'd5, 5'd4, 5'd3}, {4{5'd19}}, 0, lat, fills, lk_sc);
    check("t2_latency", lat, 49);
    check("t2_lines", bus.lines_cleared, 0);
    check("t2_spawn", bus.spawn_req, 1);
    check("t2_writes", wr_cnt - w0, 24);
    check("t2_row19", mem[19], 10'h078);
    @(negedge clk);
    check("t2_idle_busy", bus.busy, 0);
    check("t2_spawn_pulse", bus.spawn_req, 0);

    // one line cleared, row above drops into its place
    preload(5'd19, 10'h387);
    preload(5'd18, 10'h001);
    do_lock({5'd6, 5'd5, 5'd4, 5'd3}, {4{5'd19}}, 0, lat, fills, lk_sc);
    check("t3_latency", lat, 50);
    check("t3_fills", fills, 1);
    check("t3_lines", bus.lines_cleared, 1);
    check("t3_total", bus.total_lines, 1);
    check("t3_row19", mem[19], 10'h001);
    check("t3_row18", mem[18], 0);

    // four lines cleared, row 10 shifts down by four
    for (int r = 16; r < 20; r++) preload(5'(r), 10'h3FE);
    preload(5'd10, 10'h155);
    do_lock({4{5'd0}}, {5'd19, 5'd18, 5'd17, 5'd16}, 0, lat, fills, lk_sc);
    check("t4_latency", lat, 53);
    check("t4_fills", fills, 4);
    check("t4_lines", bus.lines_cleared, 4);
    check("t4_total", bus.total_lines, 5);
    check("t4_row14", mem[14], 10'h155);
    z = '0;
    for (int r = 0; r < ROWS; r++) if (r != 14) z = z | mem[r];
    check("t4_rest_empty", z, 0);

    // out-of-range column is dropped without a write
    w0 = wr_cnt;
    do_lock({5'd12, 5'd2, 5'd1, 5'd0}, {4{5'd19}}, 0, lat, fills, lk_sc);
    check("t5_latency", lat, 49);
    check("t5_writes", wr_cnt - w0, 23);
    check("t5_row19", mem[19], 10'h007);
    check("t5_lines", bus.lines_cleared, 0);

    // lock_req held through the whole sequence: no re-capture
    do_lock({5'd6, 5'd5, 5'd4, 5'd3}, {4{5'd19}}, 1, lat, fills, lk_sc);
    check("hold_latency", lat, 49);
    check("hold_no_recapture", lk_sc, 0);
    check("hold_row19", mem[19], 10'h07F);
    @(negedge clk);
    check("hold_idle", state_dbg, S_IDLE);

    // reset during the scan
    @(negedge clk);
    bus.x_block = {5'd1, 5'd1, 5'd1, 5'd1}; bus.y_block = {4{5'd5}}; bus.lock_req = 1'b1;
    @(negedge clk);
    bus.lock_req = 1'b0;
    t = 0;
    while (state_dbg != S_SC_EVAL && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("reach_sc_eval", state_dbg, S_SC_EVAL);
    check("pre_reset_total", bus.total_lines, 5);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_state", state_dbg, S_INIT);
    check("midrst_total", bus.total_lines, 0);
    check("midrst_we", bus.row_we, 0);
    reset_and_init();

    // top-out: sticky, no spawn, later locks ignored
    do_lock({5'd9, 5'd8, 5'd7, 5'd4}, {5'd19, 5'd19, 5'd19, 5'd1}, 0, lat, fills, lk_sc);
    check("to_latency", lat, 49);
    check("to_flag", bus.top_out, 1);
    check("to_spawn", bus.spawn_req, 0);
    check("to_row19", mem[19], 10'h380);
    check("to_row1", mem[1], 10'h010);
    w0 = wr_cnt;
    busy_cnt = 0;
    @(negedge clk);
    bus.x_block = {4{5'd2}}; bus.y_block = {4{5'd10}}; bus.lock_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
    end
    bus.lock_req = 1'b0;
    check("to_ignore_busy", busy_cnt, 0);
    check("to_ignore_writes", wr_cnt - w0, 0);
    check("to_sticky", bus.top_out, 1);
    check("to_no_spawn", bus.spawn_req, 0);

    // only reset clears top-out
    reset_and_init();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
